pipe_hold_ctrl: RTL and testbench

PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

---
 rtl/pipe_hold_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: resolves stall requests into a hold level and sequences jump flushes and debugger halts.
// Optional bus-hold timeout detector enabled by defining PIPE_HOLD_TIMEOUT_EN.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_rib_i,
  input  logic        hold_flag_clint_i,
  input  logic        jtag_halt_flag_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("pipe_hold_ctrl: FLUSH_CYCLES or TIMEOUT_CYCLES out of range");
  end

  state_t     state;
  logic [3:0] flush_cnt;
  hold_t      req_level;

  assign jump_flag_o = jump_flag_i;
  assign jump_addr_o = jump_addr_i;

  always_comb begin
    req_level = HOLD_NONE;
    if (jump_flag_i || hold_flag_ex_i || hold_flag_clint_i) begin
      req_level = HOLD_ID;
    end else if (hold_flag_rib_i) begin
      req_level = HOLD_PC;
    end
  end

  // Outside IDLE the pipeline is frozen regardless of incoming requests.
  assign hold_flag_o = (state == IDLE) ? req_level : HOLD_ID;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (jtag_halt_flag_i) begin
            state  <= HALT;
            busy_o <= 1'b1;
          end else if (jump_flag_i) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
            busy_o    <= 1'b1;
          end
        end
        FLUSH: begin
          if (jtag_halt_flag_i) begin
            state     <= HALT;
            flush_cnt <= '0;
          end else if (jump_flag_i) begin
            flush_cnt <= FLUSH_LOAD;
          end else if (flush_cnt <= 4'd1) begin
            state     <= IDLE;
            flush_cnt <= '0;
            busy_o    <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        HALT: begin
          if (!jtag_halt_flag_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          flush_cnt <= '0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_HOLD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_SAT  = 16'(TIMEOUT_CYCLES);

  logic [15:0] rib_cnt;

  // Pulse fires on the edge the count becomes TIMEOUT_CYCLES; saturation then blocks repeats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rib_cnt   <= '0;
      timeout_o <= 1'b0;
    end else if (!hold_flag_rib_i) begin
      rib_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= (rib_cnt == TIMEOUT_LAST);
      if (rib_cnt != TIMEOUT_SAT) begin
        rib_cnt <= rib_cnt + 16'd1;
      end
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl: cycle table plus hand-written reset and timeout sequences.
module tb_pipe_hold_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_ex_i;
  logic        hold_flag_rib_i;
  logic        hold_flag_clint_i;
  logic        jtag_halt_flag_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        busy_o;
  logic        timeout_o;

  int unsigned total;
  int unsigned bad;

  pipe_hold_ctrl #(
    .FLUSH_CYCLES  (2),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .jump_flag_i      (jump_flag_i),
    .jump_addr_i      (jump_addr_i),
    .hold_flag_ex_i   (hold_flag_ex_i),
    .hold_flag_rib_i  (hold_flag_rib_i),
    .hold_flag_clint_i(hold_flag_clint_i),
    .jtag_halt_flag_i (jtag_halt_flag_i),
    .hold_flag_o      (hold_flag_o),
    .jump_flag_o      (jump_flag_o),
    .jump_addr_o      (jump_addr_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PIPE_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        jmp;
    logic [31:0] addr;
    logic        ex;
    logic        rib;
    logic        clint;
    logic        halt;
    logic [2:0]  e_hold;
    logic        e_busy;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic j, logic [31:0] a, logic e, logic rb,
                              logic c, logic h, logic [2:0] eh, logic eb);
    vec_t v;
    v.rst = r; v.jmp = j; v.addr = a; v.ex = e; v.rib = rb;
    v.clint = c; v.halt = h; v.e_hold = eh; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst               = v.rst;
    jump_flag_i       = v.jmp;
    jump_addr_i       = v.addr;
    hold_flag_ex_i    = v.ex;
    hold_flag_rib_i   = v.rib;
    hold_flag_clint_i = v.clint;
    jtag_halt_flag_i  = v.halt;
  endtask

  task automatic idle_inputs();
    jump_flag_i = 1'b0; jump_addr_i = '0; hold_flag_ex_i = 1'b0;
    hold_flag_rib_i = 1'b0; hold_flag_clint_i = 1'b0; jtag_halt_flag_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle_inputs();

    //            rst jmp addr          ex rib cl hlt hold busy
    vecs[0]  = mk(0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0); // in reset
    vecs[1]  = mk(0, 0, 32'h0,         0, 1, 0, 0, 3'd1, 0); // reset: hold follows inputs
    vecs[2]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);
    vecs[3]  = mk(1, 1, 32'h0000_0100, 0, 0, 0, 0, 3'd3, 0); // single jump
    vecs[4]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd3, 1);
    vecs[5]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd3, 1);
    vecs[6]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);
    vecs[7]  = mk(1, 1, 32'h0000_0100, 0, 0, 0, 0, 3'd3, 0); // back-to-back jumps
    vecs[8]  = mk(1, 1, 32'h0000_0200, 0, 0, 0, 0, 3'd3, 1);
    vecs[9]  = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd3, 1);
    vecs[10] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd3, 1);
    vecs[11] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);
    vecs[12] = mk(1, 1, 32'h0000_0300, 0, 0, 0, 1, 3'd3, 0); // halt over jump x5
    vecs[13] = mk(1, 1, 32'h0000_0304, 0, 0, 0, 1, 3'd3, 1);
    vecs[14] = mk(1, 1, 32'h0000_0308, 0, 0, 0, 1, 3'd3, 1);
    vecs[15] = mk(1, 1, 32'h0000_030c, 0, 0, 0, 1, 3'd3, 1);
    vecs[16] = mk(1, 1, 32'h0000_0310, 0, 0, 0, 1, 3'd3, 1);
    vecs[17] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd3, 1); // release cycle
    vecs[18] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);
    vecs[19] = mk(1, 0, 32'h0,         0, 1, 0, 0, 3'd1, 0); // priority
    vecs[20] = mk(1, 0, 32'h0,         1, 1, 0, 0, 3'd3, 0);
    vecs[21] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);
    vecs[22] = mk(1, 0, 32'h0,         0, 0, 1, 0, 3'd3, 0);
    vecs[23] = mk(1, 1, 32'hdead_beef, 0, 1, 0, 0, 3'd3, 0); // jump + rib together
    vecs[24] = mk(1, 0, 32'h0,         0, 0, 0, 1, 3'd3, 1); // halt inside FLUSH
    vecs[25] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd3, 1);
    vecs[26] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);
    vecs[27] = mk(1, 1, 32'h0000_0400, 0, 0, 0, 0, 3'd3, 0); // rib during FLUSH masked
    vecs[28] = mk(1, 0, 32'h0,         0, 1, 0, 0, 3'd3, 1);
    vecs[29] = mk(1, 0, 32'h0,         0, 1, 0, 0, 3'd3, 1);
    vecs[30] = mk(1, 0, 32'h0,         0, 1, 0, 0, 3'd1, 0);
    vecs[31] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);
    vecs[32] = mk(1, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0);

    #1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("row%0d_hold", i), 32'(hold_flag_o), 32'(vecs[i].e_hold));
      chk($sformatf("row%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
      chk($sformatf("row%0d_jflag", i), 32'(jump_flag_o), 32'(vecs[i].jmp));
      chk($sformatf("row%0d_jaddr", i), jump_addr_o, vecs[i].addr);
      chk($sformatf("row%0d_timeout", i), 32'(timeout_o), 32'(0));
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-FLUSH must drop busy immediately.
    jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0500;
    @(posedge clk); #1;
    idle_inputs();
    chk("rstflush_busy_before", 32'(busy_o), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("rstflush_busy_async", 32'(busy_o), 32'(0));
    chk("rstflush_hold_async", 32'(hold_flag_o), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstflush_hold_after", 32'(hold_flag_o), 32'(0));
    chk("rstflush_busy_after", 32'(busy_o), 32'(0));
    @(posedge clk); #1;
    chk("rstflush_busy_idle", 32'(busy_o), 32'(0));

    // Reset asserted mid-HALT.
    jtag_halt_flag_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rsthalt_busy_before", 32'(busy_o), 32'(1));
    rst = 1'b0;
    #1;
    chk("rsthalt_busy_async", 32'(busy_o), 32'(0));
    jtag_halt_flag_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rsthalt_hold_after", 32'(hold_flag_o), 32'(0));
    chk("rsthalt_busy_after", 32'(busy_o), 32'(0));

    // Bus-hold timeout: rib high for 10 edges, pulse only after the 4th.
    hold_flag_rib_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("to_run1_edge%0d", i), 32'(timeout_o), 32'(TO_EN && (i == 4)));
      chk($sformatf("to_run1_hold%0d", i), 32'(hold_flag_o), 32'(1));
    end
    hold_flag_rib_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("to_gap", 32'(timeout_o), 32'(0));
    hold_flag_rib_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("to_run2_edge%0d", i), 32'(timeout_o), 32'(TO_EN && (i == 4)));
    end
    hold_flag_rib_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("to_end", 32'(timeout_o), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
